// File: rtl/frame_read_sequencer.sv
// Frame read sequencer: walks a WIDTH x HEIGHT image in pixel pairs,
// framing the reads with a start-up V_sync phase and a per-row H_sync
// blanking phase, with downstream back-pressure and abort support.
//
// state  | meaning
// IDLE   | waiting for start; row/col/pair_count keep last frame values
// VSYNC  | start-up delay, V_sync high for START_UP_DELAY cycles
// HSYNC  | per-row blanking for H_SYNC_DELAY cycles
// DATA   | active line; one pixel pair read per cycle when out_ready
// DONE   | one-cycle completion pulse, then back to IDLE
module frame_read_sequencer #(
    parameter int WIDTH          = 768,
    parameter int HEIGHT         = 512,
    parameter int START_UP_DELAY = 100,
    parameter int H_SYNC_DELAY   = 150
) (
    input  logic        i_clk,
    input  logic        i_rst_n,
    input  logic        i_start,
    input  logic        i_abort,
    input  logic        i_out_ready,
    output logic        o_v_sync,
    output logic        o_h_sync,
    output logic        o_rd_en,
    output logic [18:0] o_rd_addr,
    output logic [9:0]  o_row,
    output logic [10:0] o_col,
    output logic [17:0] o_pair_count,
    output logic        o_busy,
    output logic        o_rd_done
);

    // Counters sized to hold their terminal value without wrapping.
    localparam int VCNT_W = $clog2(START_UP_DELAY + 1);
    localparam int HCNT_W = $clog2(H_SYNC_DELAY + 1);

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_VSYNC = 3'd1,
        S_HSYNC = 3'd2,
        S_DATA  = 3'd3,
        S_DONE  = 3'd4
    } state_t;

    state_t              r_state;
    logic [VCNT_W-1:0]   r_vcnt;
    logic [HCNT_W-1:0]   r_hcnt;
    logic [9:0]          r_row;
    logic [10:0]         r_col;
    logic [17:0]         r_pair_count;
    logic                r_v_sync;
    logic                r_h_sync;
    logic                r_busy;
    logic                r_rd_done;
    logic                w_rd_en;
    logic [18:0]         w_rd_addr;

    // Read strobe and address follow the current position directly.
    always_comb begin
        w_rd_en   = (r_state == S_DATA) && i_out_ready;
        w_rd_addr = 19'(r_row) * 19'(WIDTH) + 19'(r_col);
    end

    // Sequencer state, position counters and registered status outputs.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_state      <= S_IDLE;
            r_vcnt       <= '0;
            r_hcnt       <= '0;
            r_row        <= '0;
            r_col        <= '0;
            r_pair_count <= '0;
            r_v_sync     <= 1'b0;
            r_h_sync     <= 1'b0;
            r_busy       <= 1'b0;
            r_rd_done    <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (i_start && !i_abort) begin
                        r_state      <= S_VSYNC;
                        r_vcnt       <= '0;
                        r_hcnt       <= '0;
                        r_row        <= '0;
                        r_col        <= '0;
                        r_pair_count <= '0;
                        r_v_sync     <= 1'b1;
                        r_busy       <= 1'b1;
                    end
                end
                S_VSYNC, S_HSYNC, S_DATA: begin
                    if (i_abort) begin
                        // Cancelled frames leave no trace of partial progress.
                        r_state      <= S_IDLE;
                        r_row        <= '0;
                        r_col        <= '0;
                        r_pair_count <= '0;
                        r_v_sync     <= 1'b0;
                        r_h_sync     <= 1'b0;
                        r_busy       <= 1'b0;
                    end else if (r_state == S_VSYNC) begin
                        r_vcnt <= r_vcnt + 1'b1;
                        if (r_vcnt == VCNT_W'(START_UP_DELAY - 1)) begin
                            r_state  <= S_HSYNC;
                            r_hcnt   <= '0;
                            r_v_sync <= 1'b0;
                        end
                    end else if (r_state == S_HSYNC) begin
                        r_hcnt <= r_hcnt + 1'b1;
                        if (r_hcnt == HCNT_W'(H_SYNC_DELAY - 1)) begin
                            r_state  <= S_DATA;
                            r_h_sync <= 1'b1;
                        end
                    end else if (i_out_ready) begin
                        r_pair_count <= r_pair_count + 18'd1;
                        if (r_col == 11'(WIDTH - 2)) begin
                            r_col    <= '0;
                            r_h_sync <= 1'b0;
                            if (r_row == 10'(HEIGHT - 1)) begin
                                r_state   <= S_DONE;
                                r_rd_done <= 1'b1;
                            end else begin
                                r_row   <= r_row + 10'd1;
                                r_hcnt  <= '0;
                                r_state <= S_HSYNC;
                            end
                        end else begin
                            r_col <= r_col + 11'd2;
                        end
                    end
                end
                S_DONE: begin
                    // Abort and start are both ignored here.
                    r_state   <= S_IDLE;
                    r_rd_done <= 1'b0;
                    r_busy    <= 1'b0;
                end
                default: begin
                    r_state   <= S_IDLE;
                    r_v_sync  <= 1'b0;
                    r_h_sync  <= 1'b0;
                    r_busy    <= 1'b0;
                    r_rd_done <= 1'b0;
                end
            endcase
        end
    end

    assign o_v_sync     = r_v_sync;
    assign o_h_sync     = r_h_sync;
    assign o_rd_en      = w_rd_en;
    assign o_rd_addr    = w_rd_addr;
    assign o_row        = r_row;
    assign o_col        = r_col;
    assign o_pair_count = r_pair_count;
    assign o_busy       = r_busy;
    assign o_rd_done    = r_rd_done;

endmodule

// File: tb/tb_frame_read_sequencer.sv
// Testbench for frame_read_sequencer: directed frames with waveform checks
// plus randomized back-pressure frames, all reads checked by a scoreboard.
module tb_frame_read_sequencer;

    localparam int W   = 8;
    localparam int H   = 4;
    localparam int SUD = 3;
    localparam int HSD = 2;
    localparam int PAIRS = W * H / 2;

    logic        clk;
    logic        rst_n;
    logic        start;
    logic        abort;
    logic        out_ready;
    logic        o_v_sync;
    logic        o_h_sync;
    logic        o_rd_en;
    logic [18:0] o_rd_addr;
    logic [9:0]  o_row;
    logic [10:0] o_col;
    logic [17:0] o_pair_count;
    logic        o_busy;
    logic        o_rd_done;

    frame_read_sequencer #(
        .WIDTH(W), .HEIGHT(H), .START_UP_DELAY(SUD), .H_SYNC_DELAY(HSD)
    ) dut (
        .i_clk(clk), .i_rst_n(rst_n), .i_start(start), .i_abort(abort),
        .i_out_ready(out_ready), .o_v_sync(o_v_sync), .o_h_sync(o_h_sync),
        .o_rd_en(o_rd_en), .o_rd_addr(o_rd_addr), .o_row(o_row), .o_col(o_col),
        .o_pair_count(o_pair_count), .o_busy(o_busy), .o_rd_done(o_rd_done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        int addr;
        int row;
        int col;
        int pc;
    } rd_exp_t;

    rd_exp_t rd_q[$];
    int      done_q[$];
    int      n_checks = 0;
    int      n_fail   = 0;

    task automatic check(input string name, input int act, input int exp);
        n_checks++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    // Ideal waveform of a frame read with out_ready held high; cycle 1 is
    // the first cycle after the edge that accepted start.
    function automatic bit exp_v(input int c);
        return (c >= 1) && (c <= SUD);
    endfunction

    function automatic bit exp_h(input int c);
        int u;
        u = c - (SUD + 1);
        if (u < 0) return 1'b0;
        return ((u / (HSD + W/2)) < H) && ((u % (HSD + W/2)) >= HSD);
    endfunction

    function automatic int reads_before(input int c);
        int n;
        n = 0;
        for (int k = 1; k < c; k++) if (exp_h(k)) n++;
        return n;
    endfunction

    // Every frame reads each pixel pair once, in raster order.
    task automatic push_frame();
        rd_exp_t e;
        for (int r = 0; r < H; r++) begin
            for (int p = 0; p < W/2; p++) begin
                e.addr = W*r + 2*p;
                e.row  = r;
                e.col  = 2*p;
                e.pc   = r*(W/2) + p;
                rd_q.push_back(e);
            end
        end
        done_q.push_back(PAIRS);
    endtask

    // Scoreboard monitor: pops an expectation for every read and completion.
    always @(negedge clk) begin
        rd_exp_t e;
        int      pc;
        if (rst_n === 1'b1) begin
            if (o_rd_en) begin
                check("rd_expected", int'(rd_q.size() > 0), 1);
                if (rd_q.size() > 0) begin
                    e = rd_q.pop_front();
                    check("rd_addr", int'(o_rd_addr), e.addr);
                    check("rd_row", int'(o_row), e.row);
                    check("rd_col", int'(o_col), e.col);
                    check("rd_pair_count", int'(o_pair_count), e.pc);
                    check("rd_h_sync", int'(o_h_sync), 1);
                end
            end
            if (o_rd_done) begin
                check("done_expected", int'(done_q.size() > 0), 1);
                if (done_q.size() > 0) begin
                    pc = done_q.pop_front();
                    check("done_pair_count", int'(o_pair_count), pc);
                    check("done_busy", int'(o_busy), 1);
                    check("done_all_reads", rd_q.size(), 0);
                end
            end
        end
    end

    task automatic check_all_zero(input string tag);
        check({tag, "_v_sync"}, int'(o_v_sync), 0);
        check({tag, "_h_sync"}, int'(o_h_sync), 0);
        check({tag, "_rd_en"}, int'(o_rd_en), 0);
        check({tag, "_busy"}, int'(o_busy), 0);
        check({tag, "_rd_done"}, int'(o_rd_done), 0);
        check({tag, "_row"}, int'(o_row), 0);
        check({tag, "_col"}, int'(o_col), 0);
        check({tag, "_pair_count"}, int'(o_pair_count), 0);
        check({tag, "_rd_addr"}, int'(o_rd_addr), 0);
    endtask

    // Directed frame: optional stall window, abort cycle and start spamming.
    task automatic frame(input int stall_at, input int stall_len, input int abort_at, input bit spam);
        int done_t;
        int last_c;
        int n;
        done_t = SUD + H*(HSD + W/2) + 1 + stall_len;
        last_c = (abort_at > 0) ? abort_at + 4 : done_t + 5;
        push_frame();
        @(posedge clk); #1;
        start = 1'b1; abort = 1'b0; out_ready = 1'b1;
        for (int c = 1; c <= last_c; c++) begin
            @(posedge clk); #1;
            start     = spam && (c == 1 || c == 2 || c == 7 || c == done_t);
            abort     = (c == abort_at) || (spam && c == done_t);
            out_ready = !(c >= stall_at && c < stall_at + stall_len) && (c != abort_at);
            if (c == abort_at) begin
                rd_q.delete();
                done_q.delete();
            end
            #1;
            if (abort_at < 0 || c <= abort_at) begin
                if (stall_len == 0) begin
                    check("wave_v_sync", int'(o_v_sync), int'(exp_v(c)));
                    check("wave_h_sync", int'(o_h_sync), int'(exp_h(c)));
                end
                if (abort_at < 0) begin
                    check("wave_rd_done", int'(o_rd_done), int'(c == done_t));
                    check("wave_busy", int'(o_busy), int'(c >= 1 && c <= done_t));
                end
            end
            if (abort_at < 0 && c > done_t) begin
                check("idle_hold_pair_count", int'(o_pair_count), PAIRS);
                check("idle_hold_row", int'(o_row), H - 1);
                check("idle_hold_col", int'(o_col), 0);
            end
            if (abort_at > 0 && c > abort_at) check_all_zero("after_abort");
            if (stall_len > 0 && c >= stall_at && c <= stall_at + stall_len) begin
                n = reads_before(stall_at);
                check("stall_h_sync", int'(o_h_sync), 1);
                check("stall_row", int'(o_row), n / (W/2));
                check("stall_col", int'(o_col), 2 * (n % (W/2)));
                check("stall_pair_count", int'(o_pair_count), n);
                if (c < stall_at + stall_len) check("stall_rd_en", int'(o_rd_en), 0);
            end
        end
        start = 1'b0;
        abort = 1'b0;
    endtask

    // Reset asserted mid-frame, then a long idle stretch without start.
    task automatic reset_mid_frame();
        push_frame();
        @(posedge clk); #1;
        start = 1'b1; out_ready = 1'b1;
        for (int c = 1; c <= 14; c++) begin
            @(posedge clk); #1;
            start = 1'b0;
        end
        rst_n = 1'b0;
        rd_q.delete();
        done_q.delete();
        #1;
        check_all_zero("async_reset");
        repeat (3) @(posedge clk);
        #1 rst_n = 1'b1;
        for (int c = 0; c < 50; c++) begin
            @(posedge clk); #2;
            check("post_reset_busy", int'(o_busy), 0);
            check("post_reset_v_sync", int'(o_v_sync), 0);
        end
    endtask

    // Frame with random back-pressure and stray start pulses.
    task automatic rand_frame();
        bit seen;
        seen = 1'b0;
        push_frame();
        @(posedge clk); #1;
        start = 1'b1; out_ready = 1'($urandom_range(1));
        for (int c = 1; c <= 3000; c++) begin
            @(posedge clk); #1;
            start     = ($urandom_range(7) == 0);
            out_ready = ($urandom_range(99) < 65);
            #1;
            if (o_rd_done) begin
                seen = 1'b1;
                break;
            end
        end
        start = 1'b0;
        check("rand_done_seen", int'(seen), 1);
        repeat (3) @(posedge clk);
        #2;
        check("rand_idle_busy", int'(o_busy), 0);
        check("rand_idle_pair_count", int'(o_pair_count), PAIRS);
    endtask

    initial begin
        rst_n = 1'b1; start = 1'b0; abort = 1'b0; out_ready = 1'b0;
        #1 rst_n = 1'b0;
        #2;
        check_all_zero("reset");
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
        repeat (5) @(posedge clk);
        #2;
        check("idle_after_reset_busy", int'(o_busy), 0);

        frame(-1, 0, -1, 1'b0);
        frame(13, 5, -1, 1'b0);
        frame(-1, 0, 19, 1'b0);
        frame(-1, 0, -1, 1'b0);
        frame(-1, 0, -1, 1'b1);
        reset_mid_frame();
        frame(-1, 0, -1, 1'b0);
        for (int i = 0; i < 4; i++) rand_frame();

        repeat (2) @(posedge clk);
        check("final_rd_q_empty", rd_q.size(), 0);
        check("final_done_q_empty", done_q.size(), 0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
